// File: rtl/boolean_pipe.sv
// Pipelined bitwise 3-input function unit (AOI21/OAI21/majority/parity).
// Optional result popcount output enabled by defining BOOL_POPCOUNT_EN.
module boolean_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     d,
`ifdef BOOL_POPCOUNT_EN
  output logic [$clog2(W+1)-1:0] d_pop,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  logic              adv;
  logic [W-1:0]      f;
  logic [STAGES-1:0] vld_q;
  logic [W-1:0]      dat_q [STAGES];
  logic [CNT_W-1:0]  cnt_q;

  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign d         = dat_q[STAGES-1];
  assign xfer_cnt  = cnt_q;

  always_comb begin
    f = '0;
    unique case (mode)
      2'd0: f = ~((a & b) | c);
      2'd1: f = ~((a | b) & c);
      2'd2: f = (a & b) | (a & c) | (b & c);
      2'd3: f = a ^ b ^ c;
      default: f = '0;
    endcase
  end

  // Data only moves with a valid token, so d keeps its last result
  // while bubbles pass through the output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= f;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else if (out_valid && out_ready) cnt_q <= cnt_q + CNT_W'(1);
  end

`ifdef BOOL_POPCOUNT_EN
  localparam int PW = $clog2(W+1);

  logic [PW-1:0] pop_c;
  logic [PW-1:0] pop_q [STAGES];

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < W; i++) pop_c = pop_c + PW'(f[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pop_q[i] <= '0;
    end else if (adv) begin
      if (in_valid) pop_q[0] <= pop_c;
      for (int i = 1; i < STAGES; i++)
        if (vld_q[i-1]) pop_q[i] <= pop_q[i-1];
    end
  end

  assign d_pop = pop_q[STAGES-1];
`endif

endmodule
